// File: rtl/iob_cache_front_end_q_if.sv
// Processor-side request/response bundle of the cache front-end queue.
// The master drives requests; the slave (the queue) answers with ready/ack/rdata.
interface iob_cache_front_end_q_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int USE_CTRL = 0
);
    localparam int NBYTES = DATA_W / 8;

    logic [USE_CTRL+ADDR_W-1:0] addr;
    logic [DATA_W-1:0]          wdata;
    logic [NBYTES-1:0]          wstrb;
    logic                       req;
    logic                       ready;
    logic [DATA_W-1:0]          rdata;
    logic                       ack;

    modport master (
        output addr, wdata, wstrb, req,
        input  ready, rdata, ack
    );

    modport slave (
        input  addr, wdata, wstrb, req,
        output ready, rdata, ack
    );
endinterface

// File: rtl/iob_cache_front_end_q.sv
// Cache front-end request queue: buffers processor requests in order and
// steers the oldest one to either the cache data path or the cache-control
// register block, returning the completion of whichever target served it.
module iob_cache_front_end_q #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NBYTES      = DATA_W / 8,
    parameter int USE_CTRL    = 0,
    parameter int CTRL_ADDR_W = 5,
    parameter int DEPTH       = 4
) (
    input  logic                         clk_i,
    input  logic                         reset,
    iob_cache_front_end_q_if.slave       fe,
    output logic                         data_req,
    output logic [ADDR_W-1:0]            data_addr,
    output logic [DATA_W-1:0]            data_wdata,
    output logic [NBYTES-1:0]            data_wstrb,
    input  logic [DATA_W-1:0]            data_rdata,
    input  logic                         data_ack,
    output logic                         ctrl_req,
    output logic [CTRL_ADDR_W-1:0]       ctrl_addr,
    input  logic [DATA_W-1:0]            ctrl_rdata,
    input  logic                         ctrl_ack,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int AW    = USE_CTRL + ADDR_W;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [NBYTES-1:0] wstrb;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry_d;
    entry_t             head;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               err_q, err_d;
    logic               head_vld;
    logic               sel_head;
    logic               ctrl_ack_eff;
    logic               push;
    logic               pop;

    // Head decode, handshakes, completion routing and next-state computation
    always_comb begin
        wr_entry_d       = '0;
        wr_entry_d.sel   = (USE_CTRL != 0) ? fe.addr[AW-1] : 1'b0;
        wr_entry_d.addr  = fe.addr[ADDR_W-1:0];
        wr_entry_d.wdata = fe.wdata;
        wr_entry_d.wstrb = fe.wstrb;

        head     = mem_q[rptr_q];
        head_vld = (level_q != '0);
        sel_head = (USE_CTRL != 0) ? head.sel : 1'b0;

        // Without a control space the control-side ack is not connected to anything real.
        ctrl_ack_eff = (USE_CTRL != 0) ? ctrl_ack : 1'b0;

        // Ready is a function of occupancy only, so a pop at full never bypasses into a push.
        fe.ready = (level_q != LVL_W'(DEPTH));

        data_req   = head_vld & ~sel_head;
        ctrl_req   = head_vld & sel_head;
        data_addr  = head.addr;
        data_wdata = head.wdata;
        data_wstrb = head.wstrb;
        ctrl_addr  = (USE_CTRL != 0) ? head.addr[CTRL_ADDR_W-1:0] : '0;

        fe.ack   = data_ack | ctrl_ack_eff;
        fe.rdata = ctrl_ack_eff ? ctrl_rdata : data_rdata;

        push = fe.req & fe.ready;
        pop  = (data_ack & data_req) | (ctrl_ack_eff & ctrl_req);

        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Acks that do not match the head target, or both at once, are protocol errors.
        err_d = err_q
              | (data_ack & ~data_req)
              | (ctrl_ack_eff & ~ctrl_req)
              | (data_ack & ctrl_ack_eff);

        level = level_q;
        err   = err_q;
    end

    // Control state: pointers, occupancy and sticky error, cleared by reset
    always_ff @(posedge clk_i) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Entry storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry_d;
        end
    end
endmodule

// File: tb/tb_iob_cache_front_end_q.sv
module tb_iob_cache_front_end_q;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: control space enabled, 32-bit data address
    iob_cache_front_end_q_if #(.ADDR_W(32), .DATA_W(32), .USE_CTRL(1)) b1 ();
    logic        d1_data_req, d1_ctrl_req, d1_err;
    logic [31:0] d1_data_addr, d1_data_wdata, d1_data_rdata, d1_ctrl_rdata;
    logic [3:0]  d1_data_wstrb;
    logic        d1_data_ack, d1_ctrl_ack;
    logic [4:0]  d1_ctrl_addr;
    logic [2:0]  d1_level;

    iob_cache_front_end_q #(.ADDR_W(32), .DATA_W(32), .USE_CTRL(1), .CTRL_ADDR_W(5), .DEPTH(4)) u1 (
        .clk_i(clk), .reset(reset), .fe(b1),
        .data_req(d1_data_req), .data_addr(d1_data_addr), .data_wdata(d1_data_wdata),
        .data_wstrb(d1_data_wstrb), .data_rdata(d1_data_rdata), .data_ack(d1_data_ack),
        .ctrl_req(d1_ctrl_req), .ctrl_addr(d1_ctrl_addr), .ctrl_rdata(d1_ctrl_rdata),
        .ctrl_ack(d1_ctrl_ack), .level(d1_level), .err(d1_err)
    );

    // DUT 0: no control space
    iob_cache_front_end_q_if #(.ADDR_W(16), .DATA_W(32), .USE_CTRL(0)) b0 ();
    logic        d0_data_req, d0_ctrl_req, d0_err;
    logic [15:0] d0_data_addr;
    logic [31:0] d0_data_wdata, d0_data_rdata, d0_ctrl_rdata;
    logic [3:0]  d0_data_wstrb;
    logic        d0_data_ack, d0_ctrl_ack;
    logic [4:0]  d0_ctrl_addr;
    logic [2:0]  d0_level;

    iob_cache_front_end_q #(.ADDR_W(16), .DATA_W(32), .USE_CTRL(0), .CTRL_ADDR_W(5), .DEPTH(4)) u0 (
        .clk_i(clk), .reset(reset), .fe(b0),
        .data_req(d0_data_req), .data_addr(d0_data_addr), .data_wdata(d0_data_wdata),
        .data_wstrb(d0_data_wstrb), .data_rdata(d0_data_rdata), .data_ack(d0_data_ack),
        .ctrl_req(d0_ctrl_req), .ctrl_addr(d0_ctrl_addr), .ctrl_rdata(d0_ctrl_rdata),
        .ctrl_ack(d0_ctrl_ack), .level(d0_level), .err(d0_err)
    );

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;
    ent_t mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        b1.req = 1'b0; b1.addr = '0; b1.wdata = '0; b1.wstrb = '0;
        b0.req = 1'b0; b0.addr = '0; b0.wdata = '0; b0.wstrb = '0;
        d1_data_ack = 1'b0; d1_ctrl_ack = 1'b0; d1_data_rdata = '0; d1_ctrl_rdata = '0;
        d0_data_ack = 1'b0; d0_ctrl_ack = 1'b0; d0_data_rdata = '0; d0_ctrl_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ready",    64'(b1.ready), 64'(1));
        chk("rst_data_req", 64'(d1_data_req), 64'(0));
        chk("rst_ctrl_req", 64'(d1_ctrl_req), 64'(0));
        chk("rst_ack",      64'(b1.ack), 64'(0));
        chk("rst_level",    64'(d1_level), 64'(0));
        chk("rst_err",      64'(d1_err), 64'(0));
        chk("rst_ready0",   64'(b0.ready), 64'(1));

        // Single write
        b1.addr = 33'h10; b1.wdata = 32'hDEADBEEF; b1.wstrb = 4'hF; b1.req = 1'b1;
        tick();
        b1.req = 1'b0;
        #1;
        chk("w_data_req",  64'(d1_data_req), 64'(1));
        chk("w_data_addr", 64'(d1_data_addr), 64'(32'h10));
        chk("w_wdata",     64'(d1_data_wdata), 64'(32'hDEADBEEF));
        chk("w_wstrb",     64'(d1_data_wstrb), 64'(4'hF));
        chk("w_level",     64'(d1_level), 64'(1));
        d1_data_ack = 1'b1; d1_data_rdata = 32'h1234_5678;
        #1;
        chk("w_ack",   64'(b1.ack), 64'(1));
        chk("w_rdata", 64'(b1.rdata), 64'(32'h1234_5678));
        tick();
        d1_data_ack = 1'b0;
        #1;
        chk("w_level_after", 64'(d1_level), 64'(0));
        chk("w_req_after",   64'(d1_data_req), 64'(0));

        // Fill to DEPTH with no acks, then hold req while full
        for (int i = 0; i < 4; i++) begin
            b1.addr = 33'(i); b1.wdata = 32'(i) + 32'hA000; b1.wstrb = 4'h1; b1.req = 1'b1;
            #1;
            chk("fill_ready_pre", 64'(b1.ready), 64'(1));
            tick();
        end
        chk("fill_ready_full", 64'(b1.ready), 64'(0));
        chk("fill_level",      64'(d1_level), 64'(4));
        b1.addr = 33'd99;
        tick();
        tick();
        b1.req = 1'b0;
        #1;
        chk("full_hold_level", 64'(d1_level), 64'(4));
        chk("full_hold_head",  64'(d1_data_addr), 64'(0));
        for (int i = 0; i < 4; i++) begin
            d1_data_ack = 1'b1;
            #1;
            chk("drain_head",  64'(d1_data_addr), 64'(i));
            chk("drain_wdata", 64'(d1_data_wdata), 64'(32'(i) + 32'hA000));
            if (i == 0) chk("no_full_bypass", 64'(b1.ready), 64'(0));
            tick();
            d1_data_ack = 1'b0;
            #1;
            if (i == 0) chk("ready_after_pop", 64'(b1.ready), 64'(1));
        end
        chk("drain_level", 64'(d1_level), 64'(0));

        // Pointer wrap with simultaneous push and pop
        b1.addr = 33'd100; b1.req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            b1.addr = 33'(101 + i); b1.req = 1'b1; d1_data_ack = 1'b1;
            #1;
            chk("wrap_head",  64'(d1_data_addr), 64'(100 + i));
            chk("wrap_level", 64'(d1_level), 64'(1));
            tick();
        end
        b1.req = 1'b0; d1_data_ack = 1'b0;
        #1;
        chk("wrap_last_head",  64'(d1_data_addr), 64'(110));
        chk("wrap_last_level", 64'(d1_level), 64'(1));
        d1_data_ack = 1'b1;
        tick();
        d1_data_ack = 1'b0;

        // Control-space routing
        b1.addr = 33'h1_0000_0004; b1.req = 1'b1;
        tick();
        b1.addr = 33'h0_0000_0008;
        tick();
        b1.req = 1'b0;
        #1;
        chk("ctl_ctrl_req",  64'(d1_ctrl_req), 64'(1));
        chk("ctl_data_req",  64'(d1_data_req), 64'(0));
        chk("ctl_ctrl_addr", 64'(d1_ctrl_addr), 64'(4));
        d1_ctrl_ack = 1'b1; d1_ctrl_rdata = 32'hCAFE_0001; d1_data_rdata = 32'h5555_5555;
        #1;
        chk("ctl_ack",   64'(b1.ack), 64'(1));
        chk("ctl_rdata", 64'(b1.rdata), 64'(32'hCAFE_0001));
        tick();
        d1_ctrl_ack = 1'b0;
        #1;
        chk("ctl_then_data_req",  64'(d1_data_req), 64'(1));
        chk("ctl_then_ctrl_req",  64'(d1_ctrl_req), 64'(0));
        chk("ctl_then_data_addr", 64'(d1_data_addr), 64'(8));
        chk("ctl_err",            64'(d1_err), 64'(0));
        d1_data_ack = 1'b1;
        tick();
        d1_data_ack = 1'b0;

        // Spurious ack on empty queue; ctrl_ack ignored without a control space
        d1_data_ack = 1'b1;
        d0_ctrl_ack = 1'b1; d0_ctrl_rdata = 32'hBAD0_BAD0; d0_data_rdata = 32'h0000_0077;
        #1;
        chk("sp_ack",    64'(b1.ack), 64'(1));
        chk("u0_ack",    64'(b0.ack), 64'(0));
        chk("u0_rdata",  64'(b0.rdata), 64'(32'h77));
        tick();
        d1_data_ack = 1'b0; d0_ctrl_ack = 1'b0;
        #1;
        chk("sp_err",      64'(d1_err), 64'(1));
        chk("sp_level",    64'(d1_level), 64'(0));
        chk("u0_err",      64'(d0_err), 64'(0));
        tick();
        chk("sp_err_sticky", 64'(d1_err), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("sp_err_cleared", 64'(d1_err), 64'(0));

        // Reset with requests queued; an ack in the reset cycle is ignored
        for (int i = 0; i < 3; i++) begin
            b1.addr = 33'(20 + i); b1.req = 1'b1;
            tick();
        end
        b1.req = 1'b0;
        #1;
        chk("mid_level3", 64'(d1_level), 64'(3));
        reset = 1'b1; d1_ctrl_ack = 1'b1;
        tick();
        reset = 1'b0; d1_ctrl_ack = 1'b0;
        #1;
        chk("mid_level",    64'(d1_level), 64'(0));
        chk("mid_data_req", 64'(d1_data_req), 64'(0));
        chk("mid_ready",    64'(b1.ready), 64'(1));
        chk("mid_err",      64'(d1_err), 64'(0));

        // Randomized traffic against an in-order queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            ent_t        e;
            logic        do_req;
            logic        do_ack;
            logic        psh;
            logic [31:0] dr;
            logic [31:0] cr;
            do_req  = 1'($urandom);
            e.sel   = 1'($urandom);
            e.addr  = $urandom;
            e.wdata = $urandom;
            e.wstrb = 4'($urandom);
            b1.req = do_req; b1.addr = {e.sel, e.addr}; b1.wdata = e.wdata; b1.wstrb = e.wstrb;
            do_ack = (mq.size() != 0) && ($urandom_range(0, 1) == 1);
            d1_data_ack = do_ack && !mq[0].sel;
            d1_ctrl_ack = do_ack && mq[0].sel;
            dr = $urandom; cr = $urandom;
            d1_data_rdata = dr; d1_ctrl_rdata = cr;
            #1;
            chk("r_ready", 64'(b1.ready), 64'(mq.size() != 4));
            chk("r_level", 64'(d1_level), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("r_data_req", 64'(d1_data_req), 64'(!mq[0].sel));
                chk("r_ctrl_req", 64'(d1_ctrl_req), 64'(mq[0].sel));
                if (mq[0].sel) begin
                    chk("r_ctrl_addr", 64'(d1_ctrl_addr), 64'(mq[0].addr % 32));
                end else begin
                    chk("r_data_addr",  64'(d1_data_addr), 64'(mq[0].addr));
                    chk("r_data_wdata", 64'(d1_data_wdata), 64'(mq[0].wdata));
                    chk("r_data_wstrb", 64'(d1_data_wstrb), 64'(mq[0].wstrb));
                end
            end else begin
                chk("r_idle_reqs", 64'({d1_data_req, d1_ctrl_req}), 64'(0));
            end
            chk("r_ack", 64'(b1.ack), 64'(do_ack));
            if (do_ack) chk("r_rdata", 64'(b1.rdata), 64'(mq[0].sel ? cr : dr));
            psh = do_req && (mq.size() != 4);
            tick();
            if (do_ack) void'(mq.pop_front());
            if (psh) mq.push_back(e);
        end
        b1.req = 1'b0; d1_data_ack = 1'b0; d1_ctrl_ack = 1'b0;
        #1;
        chk("r_final_level", 64'(d1_level), 64'(mq.size()));
        chk("r_final_err",   64'(d1_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_cache_front_end_q.md
Name: iob_cache_front_end_q

Overview:
- Next-generation cache front-end: accepts requests with valid/ready backpressure into a parametrised in-order request queue.
- Routes each queued request to the cache data path or, when USE_CTRL=1 and the top address bit is set, to the cache-control registers.
- Returns ack/rdata from whichever target served the queue head.
- Sits between the processor-side cache port and the cache core/control block; replaces the single registered request stage.

Parameters:
- ADDR_W, 32, data-path address width (word-address bits seen by cache core)
- DATA_W, 32, data width; must be a multiple of 8
- NBYTES, DATA_W/8, derived, write-strobe width; do not override
- USE_CTRL, 0, 1 = extra top address bit selects the control-register space
- CTRL_ADDR_W, 5, control-register address width
- DEPTH, 4, request-queue entries; power of 2, >= 2

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  USE_CTRL+ADDR_W  request address; MSB = ctrl select when USE_CTRL=1
- wdata  in  DATA_W  write data
- wstrb  in  NBYTES  byte strobes; all-zero = read
- req  in  1  request valid
- ready  out  1  queue can accept; a transfer occurs when req & ready
- rdata  out  DATA_W  read data, valid with ack
- ack  out  1  one-cycle completion pulse for the oldest request
- data_req  out  1  queue head valid and targets data path
- data_addr  out  ADDR_W  head address
- data_wdata  out  DATA_W  head write data
- data_wstrb  out  NBYTES  head strobes
- data_rdata  in  DATA_W  cache read data
- data_ack  in  1  cache completed head request
- ctrl_req  out  1  queue head valid and targets control space
- ctrl_addr  out  CTRL_ADDR_W  head address LSBs
- ctrl_rdata  in  DATA_W  control read data
- ctrl_ack  in  1  control block completed head request
- level  out  $clog2(DEPTH)+1  current queue occupancy
- err  out  1  sticky: ack received with empty queue or to the wrong target

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {sel, addr[ADDR_W-1:0], wdata, wstrb}.
  - sel = addr[MSB] when USE_CTRL=1, else 0.
  - Read/write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH.
  - level holds 0..DEPTH.
- Reset (synchronous): pointers=0, level=0, err=0. Resulting outputs: ready=1, data_req=0, ctrl_req=0, ack=0.
- Push: req & ready writes the entry at the write pointer; wptr++ and level++ on that edge.
- ready = (level != DEPTH). It is purely registered-state based, with no combinational dependence on req or acks.
- Head:
  - data_req = (level!=0) & ~sel_head.
  - ctrl_req = (level!=0) & sel_head.
  - data_* and ctrl_addr show the head fields.
  - Minimum latency is 1 cycle: a request pushed at edge N appears on data_req in cycle N+1.
  - Head outputs are stable until popped.
- Pop:
  - A valid completion is (data_ack & data_req) | (ctrl_ack & ctrl_req).
  - On a valid completion: rptr++ and level-- at the edge.
- ack = data_ack | ctrl_ack, combinational.
- rdata = ctrl_ack ? ctrl_rdata : data_rdata.
- Simultaneous push and pop in one cycle: level unchanged, both pointers advance.
- Full: with level=DEPTH, a completion in that cycle does not raise ready in the same cycle. ready rises next cycle; there is no full bypass.
- Error: err is set on any of the following, and is cleared only by reset.
  - data_ack with ~data_req.
  - ctrl_ack with ~ctrl_req.
  - data_ack & ctrl_ack in the same cycle.
  - Queue state is not changed by the spurious ack.
- USE_CTRL=0:
  - ctrl_req=0, ctrl_addr=0.
  - ctrl_ack and ctrl_rdata are ignored, including for err.
- Reset mid-operation: all queued requests are discarded. Back-end acks arriving in the reset cycle are ignored.

Test Plan:
- Reset, then single write: addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> next cycle data_req=1, data_addr=0x10, data_wstrb=0xF, level=1; data_ack pulse -> ack=1, level=0.
- Fill DEPTH=4 with no acks: push addr 0..3 -> ready=0 after the 4th push; req held 2 more cycles -> level=4, nothing overwritten; ack 4× -> heads 0,1,2,3 in order, ready=1 the cycle after the first pop.
- Pointer wrap: 10 push/pop pairs with simultaneous push+pop each cycle -> level stays 1, data_addr sequence strictly increasing, no loss.
- USE_CTRL=1, ADDR_W=32: addr=0x1_00000004 then addr=0x0_00000008 -> ctrl_req with ctrl_addr=4 first; data_req only after ctrl_ack; rdata=ctrl_rdata on the ctrl_ack cycle.
- Spurious data_ack on empty queue -> err=1 and stays set, level=0; reset -> err=0.
- Reset asserted with level=3 -> next cycle level=0, data_req=0, ready=1.
